// File: rtl/safe_lock_ctrl.sv
// Master controller for the combination safe: alternating-direction code entry,
// bolt solenoid sequencing and reprogramming. Define SAFE_LOCKOUT_EN for lockout.
module safe_lock_ctrl #(
    parameter int                        CODE_LEN      = 3,
    parameter int                        VAL_W         = 8,
    parameter logic [CODE_LEN*VAL_W-1:0] DEFAULT_CODE  = 24'h123456,
    parameter int                        LOCK_PULSE    = 100,
    parameter int                        ENTRY_TIMEOUT = 10000,
    parameter int                        MAX_FAIL      = 3,
    parameter int                        LOCKOUT_TICKS = 30000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnten,
    input  logic             up,
    input  logic             dirch,
    input  logic [VAL_W-1:0] val,
    input  logic             doorCls,
    input  logic             lock,
    input  logic             open,
    input  logic             prog,
    output logic             actuateLock,
    output logic             openCls,
    output logic             safeOpen,
    output logic             clrCount,
    output logic             blank,
    output logic [2:0]       digit_idx,
    output logic [3:0]       fail_cnt,
    output logic             lockout
);

    localparam int CODE_W = CODE_LEN * VAL_W;
    localparam int MAXT_A = (LOCK_PULSE > ENTRY_TIMEOUT) ? LOCK_PULSE : ENTRY_TIMEOUT;
    localparam int MAXT_B = (MAXT_A > LOCKOUT_TICKS) ? MAXT_A : LOCKOUT_TICKS;
    localparam int MAXT   = (MAXT_B > MAX_FAIL) ? MAXT_B : MAX_FAIL;
    localparam int TW     = $clog2(MAXT + 1);

    typedef enum logic [2:0] {
        LOCKED_IDLE, ENTRY, UNLOCKING, UNLOCKED, LOCKING, PROGRAM, LOCKOUT
    } state_t;

    state_t              state;
    logic [CODE_W-1:0]   code_reg;
    logic [CODE_W-1:0]   shadow;
    logic [CODE_W-1:0]   val_ext;
    logic [3:0]          idx;
    logic                err;
    logic [TW-1:0]       timer;
    logic [TW-1:0]       idle;
    logic [VAL_W-1:0]    exp_digit;
    logic                lock_q, lock_d, open_q, open_d, prog_q, prog_d;
    logic                lock_edge, open_edge, prog_edge;
    logic                activity, timeout, unlock_ok, do_fail;
    logic [3:0]          fail_next;
`ifdef SAFE_LOCKOUT_EN
    logic                lockout_r;
    assign lockout = lockout_r;
`else
    assign lockout = 1'b0;
`endif

    // Buttons are registered, then compared with their previous sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_q <= 1'b0; lock_d <= 1'b0;
            open_q <= 1'b0; open_d <= 1'b0;
            prog_q <= 1'b0; prog_d <= 1'b0;
        end else begin
            lock_q <= lock;   lock_d <= lock_q;
            open_q <= open;   open_d <= open_q;
            prog_q <= prog;   prog_d <= prog_q;
        end
    end

    assign lock_edge = lock_q & ~lock_d;
    assign open_edge = open_q & ~open_d;
    assign prog_edge = prog_q & ~prog_d;
    assign activity  = cnten | dirch;
    assign timeout   = !activity && (idle == TW'(ENTRY_TIMEOUT - 1));
    assign unlock_ok = (idx == 4'(CODE_LEN)) && !err;
    assign do_fail   = open_edge && ((state == LOCKED_IDLE) || (state == ENTRY && !unlock_ok));
    assign fail_next = (fail_cnt == 4'hF) ? 4'hF : fail_cnt + 4'd1;
    assign val_ext   = CODE_W'(val);
    // digit_idx is only three bits wide, so an 8-digit code shows 0 when complete.
    assign digit_idx = idx[2:0];

    always_comb begin
        exp_digit = '0;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (idx == 4'(i)) exp_digit = code_reg[(CODE_LEN-1-i)*VAL_W +: VAL_W];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= LOCKED_IDLE;
            code_reg    <= DEFAULT_CODE;
            shadow      <= '0;
            idx         <= '0;
            err         <= 1'b0;
            fail_cnt    <= '0;
            timer       <= '0;
            idle        <= '0;
            actuateLock <= 1'b0;
            openCls     <= 1'b0;
            safeOpen    <= 1'b0;
            clrCount    <= 1'b0;
            blank       <= 1'b1;
`ifdef SAFE_LOCKOUT_EN
            lockout_r   <= 1'b0;
`endif
        end else begin
            clrCount <= 1'b0;
            case (state)
                LOCKED_IDLE: begin
                    if (!open_edge && cnten) begin
                        state <= ENTRY;
                        idx   <= '0;
                        err   <= 1'b0;
                        idle  <= '0;
                        blank <= 1'b0;
                    end
                end
                ENTRY: begin
                    // An open edge takes priority over a coincident dirch.
                    if (open_edge) begin
                        if (unlock_ok) begin
                            state    <= UNLOCKING;
                            fail_cnt <= '0;
                            openCls  <= 1'b1;
                            timer    <= TW'(LOCK_PULSE - 1);
                        end
                    end else if (timeout) begin
                        state    <= LOCKED_IDLE;
                        clrCount <= 1'b1;
                        blank    <= 1'b1;
                    end else begin
                        idle <= activity ? '0 : idle + 1'b1;
                        if (dirch) begin
                            if (idx == 4'(CODE_LEN)) begin
                                err <= 1'b1;
                            end else begin
                                if (val != exp_digit || up != ~idx[0]) err <= 1'b1;
                                idx <= idx + 4'd1;
                            end
                        end
                    end
                end
                UNLOCKING: begin
                    if (timer == '0) begin
                        openCls  <= 1'b0;
                        safeOpen <= 1'b1;
                        state    <= UNLOCKED;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                UNLOCKED: begin
                    if (lock_edge && doorCls) begin
                        state       <= LOCKING;
                        actuateLock <= 1'b1;
                        safeOpen    <= 1'b0;
                        timer       <= TW'(LOCK_PULSE - 1);
                    end else if (prog_edge) begin
                        state <= PROGRAM;
                        idx   <= '0;
                        idle  <= '0;
                    end
                end
                LOCKING: begin
                    if (!doorCls) begin
                        actuateLock <= 1'b0;
                        safeOpen    <= 1'b1;
                        state       <= UNLOCKED;
                    end else if (timer == '0) begin
                        actuateLock <= 1'b0;
                        clrCount    <= 1'b1;
                        blank       <= 1'b1;
                        state       <= LOCKED_IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                PROGRAM: begin
                    if (idx == 4'(CODE_LEN)) begin
                        code_reg <= shadow;
                        clrCount <= 1'b1;
                        state    <= UNLOCKED;
                    end else if (open_edge || timeout) begin
                        state <= UNLOCKED;
                    end else begin
                        idle <= activity ? '0 : idle + 1'b1;
                        // Shifting in leaves the first captured digit in the MS bits.
                        if (dirch) begin
                            shadow <= (shadow << VAL_W) | val_ext;
                            idx    <= idx + 4'd1;
                        end
                    end
                end
`ifdef SAFE_LOCKOUT_EN
                LOCKOUT: begin
                    if (timer == '0) begin
                        lockout_r <= 1'b0;
                        fail_cnt  <= '0;
                        state     <= LOCKED_IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
`endif
                default: state <= LOCKED_IDLE;
            endcase

            if (do_fail) begin
                fail_cnt <= fail_next;
                clrCount <= 1'b1;
                blank    <= 1'b1;
`ifdef SAFE_LOCKOUT_EN
                if (fail_next == 4'(MAX_FAIL)) begin
                    state     <= LOCKOUT;
                    lockout_r <= 1'b1;
                    timer     <= TW'(LOCKOUT_TICKS - 1);
                end else begin
                    state <= LOCKED_IDLE;
                end
`else
                state <= LOCKED_IDLE;
`endif
            end
        end
    end

endmodule
